// File: rtl/sat_sub_accumulator_if.sv
// rtl/sat_sub_accumulator_if.sv - operand/result handshake bundle for sat_sub_accumulator
interface sat_sub_accumulator_if;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] in_a;
    logic       in_last;
    logic       clear;
    logic       out_valid;
    logic       out_ready;
    logic [3:0] acc;
    logic       sat_hi;
    logic       sat_lo;

    modport master (
        output in_valid, in_a, in_last, clear, out_ready,
        input  in_ready, out_valid, acc, sat_hi, sat_lo
    );

    modport slave (
        input  in_valid, in_a, in_last, clear, out_ready,
        output in_ready, out_valid, acc, sat_hi, sat_lo
    );
endinterface

// File: rtl/sat_sub_accumulator.sv
// rtl/sat_sub_accumulator.sv - framed 4-bit signed subtract-accumulator with sticky saturation flags
module sat_sub_accumulator (
    input  logic                  clk,
    input  logic                  rst_n,
    sat_sub_accumulator_if.slave  bus
);
    typedef enum logic {ACCUM = 1'b0, HOLD = 1'b1} state_t;

    state_t     state_q, state_d;
    logic [3:0] acc_q, acc_d;
    logic       hi_q, hi_d;
    logic       lo_q, lo_d;

    logic       accept;
    logic [3:0] base;
    logic [4:0] diff;
    logic       over;
    logic       under;
    logic [3:0] sat_val;

    assign accept = bus.in_valid && (state_q == ACCUM);

    // A clear arriving with a beat restarts the frame, so the beat subtracts from 0.
    assign base    = bus.clear ? 4'd0 : acc_q;
    assign diff    = {base[3], base} - {bus.in_a[3], bus.in_a};
    assign over    = !diff[4] && diff[3];
    assign under   = diff[4] && !diff[3];
    assign sat_val = over ? 4'b0111 : (under ? 4'b1000 : diff[3:0]);

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        case (state_q)
            ACCUM: begin
                if (accept) begin
                    acc_d = sat_val;
                    hi_d  = over  | (hi_q & ~bus.clear);
                    lo_d  = under | (lo_q & ~bus.clear);
                    if (bus.in_last) begin
                        state_d = HOLD;
                    end
                end else if (bus.clear) begin
                    acc_d = 4'd0;
                    hi_d  = 1'b0;
                    lo_d  = 1'b0;
                end
            end
            HOLD: begin
                if (bus.out_ready) begin
                    state_d = ACCUM;
                    acc_d   = 4'd0;
                    hi_d    = 1'b0;
                    lo_d    = 1'b0;
                end
            end
            default: begin
                state_d = ACCUM;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ACCUM;
            acc_q   <= 4'd0;
            hi_q    <= 1'b0;
            lo_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    assign bus.in_ready  = (state_q == ACCUM);
    assign bus.out_valid = (state_q == HOLD);
    assign bus.acc       = acc_q;
    assign bus.sat_hi    = hi_q;
    assign bus.sat_lo    = lo_q;
endmodule

// File: tb/tb_sat_sub_accumulator.sv
// tb/tb_sat_sub_accumulator.sv - directed vector bench for sat_sub_accumulator
module tb_sat_sub_accumulator;
    logic clk;
    logic rst_n;

    sat_sub_accumulator_if bus ();

    sat_sub_accumulator dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string      name;
        logic       rst_n;
        logic       clear;
        logic       valid;
        logic [3:0] a;
        logic       last;
        logic       oready;
        logic [3:0] e_acc;
        logic       e_hi;
        logic       e_lo;
        logic       e_ov;
        logic       e_ir;
    } vec_t;

    vec_t vecs[$];
    int   checks;
    int   errors;

    function automatic vec_t mk(string name, logic r, logic c, logic v, logic [3:0] a,
                                logic l, logic o, logic [3:0] ea, logic eh, logic el,
                                logic eov, logic eir);
        vec_t t;
        t.name = name; t.rst_n = r; t.clear = c; t.valid = v; t.a = a; t.last = l;
        t.oready = o; t.e_acc = ea; t.e_hi = eh; t.e_lo = el; t.e_ov = eov; t.e_ir = eir;
        return t;
    endfunction

    task automatic step(input vec_t t);
        logic [7:0] got;
        logic [7:0] exp;
        @(negedge clk);
        rst_n        = t.rst_n;
        bus.clear    = t.clear;
        bus.in_valid = t.valid;
        bus.in_a     = t.a;
        bus.in_last  = t.last;
        bus.out_ready = t.oready;
        @(posedge clk);
        #1;
        got = {bus.out_valid, bus.in_ready, bus.acc, bus.sat_hi, bus.sat_lo};
        exp = {t.e_ov, t.e_ir, t.e_acc, t.e_hi, t.e_lo};
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got ov=%b ir=%b acc=%h hi=%b lo=%b, want ov=%b ir=%b acc=%h hi=%b lo=%b",
                     t.name, got[7], got[6], got[5:2], got[1], got[0],
                     exp[7], exp[6], exp[5:2], exp[1], exp[0]);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n = 1'b0;
        bus.clear = 1'b0; bus.in_valid = 1'b0; bus.in_a = 4'd0;
        bus.in_last = 1'b0; bus.out_ready = 1'b0;

        //               name          rst clr vld a      lst ordy acc    hi lo ov ir
        vecs.push_back(mk("reset",      0, 0, 0, 4'h0, 0, 0, 4'h0, 0, 0, 0, 1));
        vecs.push_back(mk("b3",         1, 0, 1, 4'h3, 0, 0, 4'hD, 0, 0, 0, 1));
        vecs.push_back(mk("bm2",        1, 0, 1, 4'hE, 0, 0, 4'hF, 0, 0, 0, 1));
        vecs.push_back(mk("b1_last",    1, 0, 1, 4'h1, 1, 0, 4'hE, 0, 0, 1, 0));
        vecs.push_back(mk("drain1",     1, 0, 0, 4'h0, 0, 1, 4'h0, 0, 0, 0, 1));
        vecs.push_back(mk("b7",         1, 0, 1, 4'h7, 0, 0, 4'h9, 0, 0, 0, 1));
        vecs.push_back(mk("b7_last_lo", 1, 0, 1, 4'h7, 1, 0, 4'h8, 0, 1, 1, 0));
        vecs.push_back(mk("drain2",     1, 0, 0, 4'h0, 0, 1, 4'h0, 0, 0, 0, 1));
        vecs.push_back(mk("bm8_last_hi",1, 0, 1, 4'h8, 1, 0, 4'h7, 1, 0, 1, 0));
        vecs.push_back(mk("drain3",     1, 0, 0, 4'h0, 0, 1, 4'h0, 0, 0, 0, 1));
        vecs.push_back(mk("bm8_hi",     1, 0, 1, 4'h8, 0, 0, 4'h7, 1, 0, 0, 1));
        vecs.push_back(mk("b7_sticky",  1, 0, 1, 4'h7, 1, 0, 4'h0, 1, 0, 1, 0));
        vecs.push_back(mk("drain4",     1, 0, 0, 4'h0, 0, 1, 4'h0, 0, 0, 0, 1));
        vecs.push_back(mk("both_a",     1, 0, 1, 4'h8, 0, 0, 4'h7, 1, 0, 0, 1));
        vecs.push_back(mk("idle_hold",  1, 0, 0, 4'h3, 0, 1, 4'h7, 1, 0, 0, 1));
        vecs.push_back(mk("both_b",     1, 0, 1, 4'h7, 0, 0, 4'h0, 1, 0, 0, 1));
        vecs.push_back(mk("both_c",     1, 0, 1, 4'h7, 0, 0, 4'h9, 1, 0, 0, 1));
        vecs.push_back(mk("both_d",     1, 0, 1, 4'h7, 1, 0, 4'h8, 1, 1, 1, 0));
        vecs.push_back(mk("drain5",     1, 0, 0, 4'h0, 0, 1, 4'h0, 0, 0, 0, 1));
        vecs.push_back(mk("b4",         1, 0, 1, 4'h4, 0, 0, 4'hC, 0, 0, 0, 1));
        vecs.push_back(mk("b4_edge",    1, 0, 1, 4'h4, 0, 0, 4'h8, 0, 0, 0, 1));
        vecs.push_back(mk("clr_beat2",  1, 1, 1, 4'h2, 0, 0, 4'hE, 0, 0, 0, 1));
        vecs.push_back(mk("clr_alone",  1, 1, 0, 4'h5, 0, 0, 4'h0, 0, 0, 0, 1));
        vecs.push_back(mk("pre_hi",     1, 0, 1, 4'h8, 0, 0, 4'h7, 1, 0, 0, 1));
        vecs.push_back(mk("clr_last",   1, 1, 1, 4'hF, 1, 0, 4'h1, 0, 0, 1, 0));
        vecs.push_back(mk("drain6",     1, 0, 0, 4'h0, 0, 1, 4'h0, 0, 0, 0, 1));
        vecs.push_back(mk("b77_nosat",  1, 0, 1, 4'h9, 0, 0, 4'h7, 0, 0, 0, 1));
        vecs.push_back(mk("b7_zero",    1, 0, 1, 4'h7, 0, 0, 4'h0, 0, 0, 0, 1));
        vecs.push_back(mk("clr_reset",  1, 1, 0, 4'h0, 0, 0, 4'h0, 0, 0, 0, 1));
        vecs.push_back(mk("bm5_last",   1, 0, 1, 4'hB, 1, 0, 4'h5, 0, 0, 1, 0));
        vecs.push_back(mk("rst_hold",   0, 0, 1, 4'h3, 0, 0, 4'h0, 0, 0, 0, 1));
        vecs.push_back(mk("post_rst",   1, 0, 0, 4'h0, 0, 0, 4'h0, 0, 0, 0, 1));
        vecs.push_back(mk("mid_a",      1, 0, 1, 4'h8, 0, 0, 4'h7, 1, 0, 0, 1));
        vecs.push_back(mk("rst_mid",    0, 1, 1, 4'h2, 1, 1, 4'h0, 0, 0, 0, 1));

        foreach (vecs[i]) step(vecs[i]);

        // Result parked in HOLD: beats, clear and stalled consumer must not disturb it.
        step(mk("hold_enter", 1, 0, 1, 4'h5, 1, 0, 4'hB, 0, 0, 1, 0));
        for (int k = 0; k < 3; k++) begin
            step(mk("hold_stall", 1, 1, 1, 4'h5, 0, 0, 4'hB, 0, 0, 1, 0));
        end
        step(mk("hold_release", 1, 0, 1, 4'h5, 0, 1, 4'h0, 0, 0, 0, 1));
        step(mk("after_release", 1, 0, 1, 4'h2, 0, 0, 4'hE, 0, 0, 0, 1));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
